// File: rtl/alu_req_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_req_sequencer_if
// Bundles every handshake and bus signal around alu_req_sequencer:
//   req0_* / req1_* : two requesters (valid/ready handshake, op, a, b)
//   alu_*           : operand bus to and result bus from the shared ALU
//   rsp_*           : tagged result channel (valid/ready handshake)
//   busy            : sequencer status
// Modports:
//   slave  - the sequencer's view (takes requests, drives the ALU, returns results)
//   master - the environment's view (requesters, ALU and result consumer)
// ---------------------------------------------------------------------------
interface alu_req_sequencer_if #(
    parameter int W = 3
);
    logic         req0_valid;
    logic         req0_ready;
    logic [1:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [1:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic [1:0]   alu_ins;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_s;
    logic         alu_ov;
    logic         alu_cout;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_s;
    logic         rsp_ov;
    logic         rsp_cout;

    logic         busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_ins, alu_a, alu_b,
        input  alu_s, alu_ov, alu_cout,
        output rsp_valid, rsp_id, rsp_s, rsp_ov, rsp_cout,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_ins, alu_a, alu_b,
        output alu_s, alu_ov, alu_cout,
        input  rsp_valid, rsp_id, rsp_s, rsp_ov, rsp_cout,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_req_sequencer.sv
// ---------------------------------------------------------------------------
// alu_req_sequencer
// Shares one combinational ALU between two requesters. A round-robin grant
// picks one pending request, the operands are latched onto the ALU bus and
// held for SETTLE cycles, then S/OV/Cout are captured and returned tagged
// with the requester id. The op code is passed through, never interpreted.
//
// Parameters:
//   W      operand/result width (must match the interface W)
//   SETTLE cycles the ALU inputs are held before capture, 1..15
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_req_sequencer_if.slave (requests, ALU bus, response, busy)
// ---------------------------------------------------------------------------
module alu_req_sequencer #(
    parameter int W      = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_req_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t       state_reg, state_next;
    logic         prio_reg, prio_next;          // requester that wins the next tie
    logic [1:0]   alu_ins_reg, alu_ins_next;
    logic [W-1:0] alu_a_reg, alu_a_next;
    logic [W-1:0] alu_b_reg, alu_b_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic         rsp_valid_reg, rsp_valid_next;
    logic         rsp_id_reg, rsp_id_next;
    logic [W-1:0] rsp_s_reg, rsp_s_next;
    logic         rsp_ov_reg, rsp_ov_next;
    logic         rsp_cout_reg, rsp_cout_next;

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic         grant_valid;
    logic         winner;
    logic [1:0]   sel_op;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;

    assign req_valid   = {bus.req1_valid, bus.req0_valid};
    assign grant_valid = |req_valid;
    // A lone request wins outright; a tie goes to the priority pointer.
    assign winner      = (&req_valid) ? prio_reg : req_valid[1];

    assign sel_op = winner ? bus.req1_op : bus.req0_op;
    assign sel_a  = winner ? bus.req1_a  : bus.req0_a;
    assign sel_b  = winner ? bus.req1_b  : bus.req0_b;

    // Ready is offered only in IDLE and only to the grant winner. It is
    // also gated by rst_n so every output reads 0 while reset is held.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && (state_reg == ST_IDLE) &&
                                   req_valid[gi] && (winner == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    // ---------------------------------------------------------------
    // Next-state / datapath
    // ---------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        prio_next      = prio_reg;
        alu_ins_next   = alu_ins_reg;
        alu_a_next     = alu_a_reg;
        alu_b_next     = alu_b_reg;
        cnt_next       = cnt_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_s_next     = rsp_s_reg;
        rsp_ov_next    = rsp_ov_reg;
        rsp_cout_next  = rsp_cout_reg;

        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    alu_ins_next = sel_op;
                    alu_a_next   = sel_a;
                    alu_b_next   = sel_b;
                    rsp_id_next  = winner;
                    cnt_next     = SETTLE_CNT;
                    prio_next    = ~winner;
                    state_next   = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                // cnt==0 cannot occur from a legal load; treating it like
                // cnt==1 guarantees the state always exits.
                if (cnt_reg <= 4'd1) begin
                    rsp_s_next     = bus.alu_s;
                    rsp_ov_next    = bus.alu_ov;
                    rsp_cout_next  = bus.alu_cout;
                    rsp_valid_next = 1'b1;
                    cnt_next       = 4'd0;
                    state_next     = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                rsp_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            prio_reg      <= 1'b0;
            alu_ins_reg   <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            cnt_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_s_reg     <= '0;
            rsp_ov_reg    <= 1'b0;
            rsp_cout_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prio_reg      <= prio_next;
            alu_ins_reg   <= alu_ins_next;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            cnt_reg       <= cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_s_reg     <= rsp_s_next;
            rsp_ov_reg    <= rsp_ov_next;
            rsp_cout_reg  <= rsp_cout_next;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.alu_ins   = alu_ins_reg;
    assign bus.alu_a     = alu_a_reg;
    assign bus.alu_b     = alu_b_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_s     = rsp_s_reg;
    assign bus.rsp_ov    = rsp_ov_reg;
    assign bus.rsp_cout  = rsp_cout_reg;
    assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_req_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_req_sequencer
// Self-checking bench for alu_req_sequencer: a SETTLE=1 instance driven by a
// vector table plus hand-written arbitration, back-pressure and reset
// sequences, and a SETTLE=3 instance for the latency check. The ALU stub
// computes S=(A+B) mod 2^W, Cout=carry, OV=signed overflow.
// ---------------------------------------------------------------------------
module tb_alu_req_sequencer;

    localparam int W = 3;

    logic clk;
    logic rst_n;

    alu_req_sequencer_if #(.W(W)) bus  ();
    alu_req_sequencer_if #(.W(W)) bus3 ();

    alu_req_sequencer #(.W(W), .SETTLE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_req_sequencer #(.W(W), .SETTLE(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stubs
    logic [W:0] sum1, sum3;
    always_comb begin
        sum1          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_s     = sum1[W-1:0];
        bus.alu_cout  = sum1[W];
        bus.alu_ov    = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (sum1[W-1] != bus.alu_a[W-1]);
        sum3          = {1'b0, bus3.alu_a} + {1'b0, bus3.alu_b};
        bus3.alu_s    = sum3[W-1:0];
        bus3.alu_cout = sum3[W];
        bus3.alu_ov   = (bus3.alu_a[W-1] == bus3.alu_b[W-1]) && (sum3[W-1] != bus3.alu_a[W-1]);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         sel;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_s;
        logic         exp_ov;
        logic         exp_cout;
    } vec_t;

    vec_t vec[8];

    task automatic drive_req(input logic sel, input logic [1:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        if (sel) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic clear_req();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        // sel op  a  b  -> s  ov cout
        vec[0] = '{1'b0, 2'b00, 3'd2, 3'd1, 3'd3, 1'b0, 1'b0};
        vec[1] = '{1'b0, 2'b01, 3'd3, 3'd2, 3'd5, 1'b1, 1'b0};
        vec[2] = '{1'b1, 2'b10, 3'd4, 3'd2, 3'd6, 1'b0, 1'b0};
        vec[3] = '{1'b1, 2'b11, 3'd7, 3'd1, 3'd0, 1'b0, 1'b1};
        vec[4] = '{1'b0, 2'b00, 3'd4, 3'd4, 3'd0, 1'b1, 1'b1};
        vec[5] = '{1'b1, 2'b01, 3'd5, 3'd6, 3'd3, 1'b1, 1'b1};
        vec[6] = '{1'b0, 2'b10, 3'd1, 3'd1, 3'd2, 1'b0, 1'b0};
        vec[7] = '{1'b1, 2'b00, 3'd3, 3'd3, 3'd6, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp_ready = 1'b1;
        bus3.req0_valid = 0; bus3.req0_op = 0; bus3.req0_a = 0; bus3.req0_b = 0;
        bus3.req1_valid = 0; bus3.req1_op = 0; bus3.req1_a = 0; bus3.req1_b = 0;
        bus3.rsp_ready = 1'b1;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset_alu_a", 32'(bus.alu_a), 0);
        chk("reset_rsp_s", 32'(bus.rsp_s), 0);
        rst_n = 1'b1;

        // ---- table-driven single transactions ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_req(vec[i].sel, vec[i].op, vec[i].a, vec[i].b);
            #1;
            chk($sformatf("v%0d_ready_win", i),
                32'(vec[i].sel ? bus.req1_ready : bus.req0_ready), 1);
            chk($sformatf("v%0d_ready_lose", i),
                32'(vec[i].sel ? bus.req0_ready : bus.req1_ready), 0);
            @(negedge clk);
            clear_req();
            chk($sformatf("v%0d_alu_ins", i), 32'(bus.alu_ins), 32'(vec[i].op));
            chk($sformatf("v%0d_alu_a", i), 32'(bus.alu_a), 32'(vec[i].a));
            chk($sformatf("v%0d_alu_b", i), 32'(bus.alu_b), 32'(vec[i].b));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 1);
            chk($sformatf("v%0d_rsp_valid_early", i), 32'(bus.rsp_valid), 0);
            @(negedge clk);
            chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 1);
            chk($sformatf("v%0d_rsp_id", i), 32'(bus.rsp_id), 32'(vec[i].sel));
            chk($sformatf("v%0d_rsp_s", i), 32'(bus.rsp_s), 32'(vec[i].exp_s));
            chk($sformatf("v%0d_rsp_ov", i), 32'(bus.rsp_ov), 32'(vec[i].exp_ov));
            chk($sformatf("v%0d_rsp_cout", i), 32'(bus.rsp_cout), 32'(vec[i].exp_cout));
            @(negedge clk);
            chk($sformatf("v%0d_done_valid", i), 32'(bus.rsp_valid), 0);
            chk($sformatf("v%0d_done_busy", i), 32'(bus.busy), 0);
            $display("vec %0d: id=%0d op=%0d a=%0d b=%0d -> s=%0d ov=%0d cout=%0d",
                     i, vec[i].sel, vec[i].op, vec[i].a, vec[i].b,
                     vec[i].exp_s, vec[i].exp_ov, vec[i].exp_cout);
        end
        // last vector was req1, so the next tie belongs to req0

        // ---- simultaneous requests: round robin ----
        @(negedge clk);
        drive_req(1'b0, 2'b01, 3'd3, 3'd2);
        drive_req(1'b1, 2'b10, 3'd4, 3'd2);
        #1;
        chk("tie1_ready0", 32'(bus.req0_ready), 1);
        chk("tie1_ready1", 32'(bus.req1_ready), 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        chk("tie1_ready1_drive", 32'(bus.req1_ready), 0);
        @(negedge clk);
        chk("tie1_r0_id", 32'(bus.rsp_id), 0);
        chk("tie1_r0_s", 32'(bus.rsp_s), 5);
        chk("tie1_r0_ov", 32'(bus.rsp_ov), 1);
        chk("tie1_r0_cout", 32'(bus.rsp_cout), 0);
        chk("tie1_ready1_resp", 32'(bus.req1_ready), 0);
        @(negedge clk);
        chk("tie1_ready1_idle", 32'(bus.req1_ready), 1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("tie1_r1_valid", 32'(bus.rsp_valid), 1);
        chk("tie1_r1_id", 32'(bus.rsp_id), 1);
        chk("tie1_r1_s", 32'(bus.rsp_s), 6);
        chk("tie1_r1_ov", 32'(bus.rsp_ov), 0);
        chk("tie1_r1_cout", 32'(bus.rsp_cout), 0);
        @(negedge clk);
        $display("tie sequence: req0 then req1 served");
        // req1 last: tie goes req0
        drive_req(1'b0, 2'b00, 3'd1, 3'd0);
        drive_req(1'b1, 2'b00, 3'd2, 3'd0);
        #1;
        chk("tie2_ready0", 32'(bus.req0_ready), 1);
        chk("tie2_ready1", 32'(bus.req1_ready), 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("tie2_s", 32'(bus.rsp_s), 1);
        @(negedge clk);
        // req1 still pending and alone: accepted now; then a new tie goes req0
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("tie2_r1_id", 32'(bus.rsp_id), 1);
        chk("tie2_r1_s", 32'(bus.rsp_s), 2);
        @(negedge clk);
        drive_req(1'b0, 2'b00, 3'd1, 3'd0);
        bus.req1_valid = 1'b1;
        @(negedge clk);           // req0 accepted
        clear_req();
        @(negedge clk);
        @(negedge clk);
        // req0 was last: a tie now goes to req1
        drive_req(1'b0, 2'b00, 3'd1, 3'd0);
        drive_req(1'b1, 2'b00, 3'd2, 3'd0);
        #1;
        chk("tie3_ready0", 32'(bus.req0_ready), 0);
        chk("tie3_ready1", 32'(bus.req1_ready), 1);
        @(negedge clk);
        clear_req();
        @(negedge clk);
        chk("tie3_id", 32'(bus.rsp_id), 1);
        @(negedge clk);
        $display("round robin alternation checked");

        // ---- back-pressure ----
        @(negedge clk);
        drive_req(1'b1, 2'b11, 3'd7, 3'd1);
        bus.rsp_ready = 1'b0;
        @(negedge clk);           // accepted
        bus.req1_valid = 1'b0;
        @(negedge clk);           // captured
        drive_req(1'b0, 2'b00, 3'd2, 3'd2);
        drive_req(1'b1, 2'b00, 3'd3, 3'd3);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_valid", c), 32'(bus.rsp_valid), 1);
            chk($sformatf("bp%0d_s", c), 32'(bus.rsp_s), 0);
            chk($sformatf("bp%0d_cout", c), 32'(bus.rsp_cout), 1);
            chk($sformatf("bp%0d_ov", c), 32'(bus.rsp_ov), 0);
            chk($sformatf("bp%0d_ready0", c), 32'(bus.req0_ready), 0);
            chk($sformatf("bp%0d_ready1", c), 32'(bus.req1_ready), 0);
            chk($sformatf("bp%0d_alu_a", c), 32'(bus.alu_a), 7);
            chk($sformatf("bp%0d_alu_ins", c), 32'(bus.alu_ins), 3);
            @(negedge clk);
        end
        clear_req();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.rsp_valid), 0);
        chk("bp_release_busy", 32'(bus.busy), 0);
        chk("bp_keep_alu_a", 32'(bus.alu_a), 7);
        chk("bp_keep_rsp_cout", 32'(bus.rsp_cout), 1);
        $display("back-pressure hold of 5 cycles checked");

        // ---- reset in DRIVE ----
        drive_req(1'b0, 2'b10, 3'd5, 3'd1);
        @(negedge clk);           // accepted, pointer now favours req1
        bus.req0_valid = 1'b0;
        chk("rst_pre_busy", 32'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_alu_a", 32'(bus.alu_a), 0);
        chk("rst_alu_b", 32'(bus.alu_b), 0);
        chk("rst_alu_ins", 32'(bus.alu_ins), 0);
        chk("rst_rsp_cout", 32'(bus.rsp_cout), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rst_no_rsp%0d", c), 32'(bus.rsp_valid), 0);
        end
        drive_req(1'b0, 2'b00, 3'd1, 3'd2);
        drive_req(1'b1, 2'b00, 3'd2, 3'd2);
        #1;
        chk("rst_tie_ready0", 32'(bus.req0_ready), 1);
        chk("rst_tie_ready1", 32'(bus.req1_ready), 0);
        @(negedge clk);
        clear_req();
        @(negedge clk);
        chk("rst_tie_id", 32'(bus.rsp_id), 0);
        chk("rst_tie_s", 32'(bus.rsp_s), 3);
        @(negedge clk);
        $display("reset during DRIVE checked");

        // ---- SETTLE=3 latency ----
        bus3.req0_valid = 1'b1; bus3.req0_op = 2'b00; bus3.req0_a = 3'd1; bus3.req0_b = 3'd1;
        @(negedge clk);           // accepted at the preceding edge
        bus3.req0_valid = 1'b0;
        chk("s3_edge1_valid", 32'(bus3.rsp_valid), 0);
        @(negedge clk);
        chk("s3_edge2_valid", 32'(bus3.rsp_valid), 0);
        @(negedge clk);
        chk("s3_edge3_valid_low", 32'(bus3.rsp_valid), 0);
        @(negedge clk);
        chk("s3_edge3_valid", 32'(bus3.rsp_valid), 1);
        chk("s3_rsp_s", 32'(bus3.rsp_s), 2);
        chk("s3_rsp_id", 32'(bus3.rsp_id), 0);
        @(negedge clk);
        chk("s3_done_busy", 32'(bus3.busy), 0);
        $display("SETTLE=3 latency checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
